// File: rtl/fixed_to_float_ci.sv
// Custom-instruction converter: signed fixed-point (FRAC_BITS fraction) scaled by 2^k to IEEE-754 single.
// Serial normalise (one shift per cycle), round-to-nearest-even, then pack with inf/flush saturation.
module fixed_to_float_ci #(
    parameter int unsigned FRAC_BITS = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int unsigned W     = 32;
    localparam int unsigned LZ_W  = 5;
    localparam int unsigned EXP_W = 12;
    localparam int unsigned FR_W  = 23;

    localparam logic signed [EXP_W-1:0] EXP_INF  = 12'sd255;
    localparam logic signed [EXP_W-1:0] EXP_ZERO = 12'sd0;
    localparam logic        [EXP_W-1:0] EXP_BIAS = 12'd158;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        PACK  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic                      sign_q, sign_d;
    logic                      zero_q, zero_d;
    logic [W-1:0]              mag_q, mag_d;
    logic [7:0]                adj_q, adj_d;
    logic [LZ_W-1:0]           lz_q, lz_d;
    logic [FR_W-1:0]           frac_q, frac_d;
    logic signed [EXP_W-1:0]   exp_q, exp_d;
    logic [W-1:0]              result_q, result_d;
    logic                      done_q, done_d;

    logic [W-1:0]              abs_a;
    logic                      round_inc;
    logic [FR_W:0]             frac_sum;
    logic signed [EXP_W-1:0]   exp_calc;
    logic                      unused_datab;

    assign unused_datab = ^datab[31:8];

    // Magnitude and rounding datapath
    always_comb begin
        abs_a     = dataa[31] ? W'(~dataa + W'(1)) : dataa;
        round_inc = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
        frac_sum  = {1'b0, mag_q[30:8]} + (FR_W+1)'(round_inc);
        exp_calc  = EXP_BIAS - EXP_W'(lz_q) - EXP_W'(FRAC_BITS)
                  + {{(EXP_W-8){adj_q[7]}}, adj_q} + EXP_W'(frac_sum[FR_W]);
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        mag_d    = mag_q;
        adj_d    = adj_q;
        lz_d     = lz_q;
        frac_d   = frac_q;
        exp_d    = exp_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = dataa[31];
                    mag_d   = abs_a;
                    adj_d   = datab[7:0];
                    lz_d    = '0;
                    zero_d  = (abs_a == '0);
                    state_d = (abs_a == '0) ? PACK : NORM;
                end
            end
            NORM: begin
                if (mag_q[W-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[W-2:0], 1'b0};
                    lz_d  = LZ_W'(lz_q + LZ_W'(1));
                end
            end
            ROUND: begin
                frac_d  = frac_sum[FR_W-1:0];
                exp_d   = exp_calc;
                state_d = PACK;
            end
            PACK: begin
                if (zero_q) begin
                    result_d = '0;
                end else if (exp_q >= EXP_INF) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                end else if (exp_q <= EXP_ZERO) begin
                    result_d = {sign_q, 31'h0};
                end else begin
                    result_d = {sign_q, exp_q[7:0], frac_q};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // clk_en gates every register, including the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            mag_q    <= '0;
            adj_q    <= '0;
            lz_q     <= '0;
            frac_q   <= '0;
            exp_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            mag_q    <= mag_d;
            adj_q    <= adj_d;
            lz_q     <= lz_d;
            frac_q   <= frac_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fixed_to_float_ci.sv
// Directed bench for fixed_to_float_ci: values, latency, clk_en stalls, reset abort, busy start.
module tb_fixed_to_float_ci;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    int total;
    int bad;

    fixed_to_float_ci #(.FRAC_BITS(22)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request right away (may coincide with a previous done cycle) and times it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int gap_at, input int gap_len, input bit poke);
        int lat;
        lat    = 0;
        dataa  = a;
        datab  = b;
        clk_en = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            clk_en = (n > gap_at && n <= gap_at + gap_len) ? 1'b0 : 1'b1;
            if (poke && n == 2) begin
                start = 1'b1;
                dataa = 32'h0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        clk_en = 1'b1;
        check_val({tag, "_res"}, result, exp_res);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int dcount;
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        clk_en = 1'b0;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_result", result, 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("one",      32'h0040_0000, 32'h0000_0000, 32'h3F80_0000, 12, 1000, 0, 1'b0);
        run_op("m_one",    32'hFFC0_0000, 32'h0000_0000, 32'hBF80_0000, 12, 1000, 0, 1'b0);
        run_op("zero",     32'h0000_0000, 32'h0000_0000, 32'h0000_0000,  1, 1000, 0, 1'b0);
        run_op("min_neg",  32'h8000_0000, 32'h0000_0000, 32'hC400_0000,  3, 1000, 0, 1'b0);
        run_op("rcarry",   32'h01FF_FFFF, 32'h0000_0000, 32'h4100_0000, 10, 1000, 0, 1'b0);
        run_op("lsb_bit",  32'h0040_0001, 32'h0000_0000, 32'h3F80_0002, 12, 1000, 0, 1'b0);
        run_op("sticky",   32'h4000_0001, 32'h0000_0000, 32'h4380_0000,  4, 1000, 0, 1'b0);
        run_op("tie_even", 32'h0100_0001, 32'h0000_0000, 32'h4080_0000, 10, 1000, 0, 1'b0);
        run_op("tie_odd",  32'h0100_0003, 32'h0000_0000, 32'h4080_0002, 10, 1000, 0, 1'b0);
        run_op("scale2",   32'h00C0_0000, 32'h0000_0002, 32'h4140_0000, 11, 1000, 0, 1'b0);
        run_op("hi_ign",   32'h0040_0000, 32'hFFFF_FF01, 32'h4000_0000, 12, 1000, 0, 1'b0);
        run_op("inf",      32'h7FFF_FFFF, 32'h0000_007F, 32'h7F80_0000,  4, 1000, 0, 1'b0);
        run_op("flush_p",  32'h0040_0000, 32'h0000_0080, 32'h0000_0000, 12, 1000, 0, 1'b0);
        run_op("flush_n",  32'hFFC0_0000, 32'h0000_0080, 32'h8000_0000, 12, 1000, 0, 1'b0);
        run_op("stall",    32'h0040_0000, 32'h0000_0000, 32'h3F80_0000, 17, 3, 5, 1'b0);
        run_op("busy",     32'hFFC0_0000, 32'h0000_0000, 32'hBF80_0000, 12, 1000, 0, 1'b1);

        // done and result hold while clk_en is low, then done drops on the next enabled edge
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("hold_done", 32'(done), 32'h1);
        check_val("hold_res", result, 32'hBF80_0000);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check_val("done_clr", 32'(done), 32'h0);

        // no stray done after the ignored busy start
        dcount = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check_val("no_extra", 32'(dcount), 32'h0);

        // reset in the middle of a long normalisation aborts it silently
        dataa = 32'h0000_0001;
        datab = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_res", result, 32'h0);
        check_val("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check_val("abort_nodone", 32'(dcount), 32'h0);

        run_op("recover",  32'h0000_0001, 32'h0000_0000, 32'h3480_0000, 34, 1000, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
